// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks: FSM encoding and default width.
package serial_arith_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB first, one bit per clock,
// then pulses done with diff/borrow_out valid until the next accepted start.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CNT_W-1:0] cnt_q;
  logic             bin_q;
  logic             borrow_q;
  logic             busy_q;
  logic             done_q;

  logic d_c;
  logic bout_c;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bin_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // FSM and datapath; busy/done are registered alongside the state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      cnt_q    <= '0;
      bin_q    <= 1'b0;
      borrow_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            bin_q   <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Result bits enter at the MSB so the LSB lands at bit 0 after WIDTH shifts.
          diff_q <= {d_c, diff_q[WIDTH-1:1]};
          a_q    <= {1'b0, a_q[WIDTH-1:1]};
          b_q    <= {1'b0, b_q[WIDTH-1:1]};
          bin_q  <= bout_c;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            borrow_q <= bout_c;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign diff       = diff_q;
  assign borrow_out = borrow_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomized checks of serial_subtractor at WIDTH=8.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         busy;
  logic         done;

  int tests  = 0;
  int failed = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .diff       (diff),
    .borrow_out (borrow_out),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] diff;
    logic         borrow;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One full operation; a/b are scrambled right after acceptance to prove they are ignored.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                        input logic [W-1:0] ed, input logic eb);
    int cyc;
    int bcnt;
    @(negedge clk);
    a = va;
    b = vb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~va;
    b = vb ^ 8'h5A;
    cyc  = 0;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      @(posedge clk);
      #1;
      cyc++;
    end
    check("latency", cyc, 8);
    check("busy_cycles", bcnt, 8);
    check("done_pulse", int'(done), 1);
    check("busy_at_done", int'(busy), 0);
    check("diff", int'(diff), int'(ed));
    check("borrow_out", int'(borrow_out), int'(eb));
    @(posedge clk);
    #1;
    check("done_single", int'(done), 0);
    check("diff_hold", int'(diff), int'(ed));
    check("borrow_hold", int'(borrow_out), int'(eb));
  endtask

  initial begin
    int last_done;
    int npulses;
    int nd;
    logic prev_done;
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1};
    vecs[2] = '{8'h80, 8'h80, 8'h00, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h01, 1'b1};
    vecs[4] = '{8'hFF, 8'h01, 8'hFE, 1'b0};
    vecs[5] = '{8'h01, 8'h02, 8'hFF, 1'b1};
    vecs[6] = '{8'hC3, 8'hC3, 8'h00, 1'b0};
    vecs[7] = '{8'h7F, 8'h80, 8'hFF, 1'b1};
    vecs[8] = '{8'hA5, 8'h5A, 8'h4B, 1'b0};
    vecs[9] = '{8'h10, 8'h20, 8'hF0, 1'b1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_diff", int'(diff), 0);
    check("rst_borrow", int'(borrow_out), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].diff, vecs[i].borrow);

    // Outputs hold in IDLE with start low
    repeat (3) @(posedge clk);
    #1;
    check("idle_hold_diff", int'(diff), 8'hF0);
    check("idle_hold_borrow", int'(borrow_out), 1);
    check("idle_busy", int'(busy), 0);

    // start held high: one operation every 10 cycles, mid-SHIFT a/b noise ignored
    @(negedge clk);
    a = 8'h5A;
    b = 8'h3C;
    start = 1'b1;
    last_done = -1;
    npulses   = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        npulses++;
        check("held_no_double", int'(prev_done), 0);
        check("held_diff", int'(diff), 8'h1E);
        check("held_borrow", int'(borrow_out), 0);
        if (last_done >= 0) check("held_period", c - last_done, 10);
        last_done = c;
      end
      prev_done = done;
      if (busy) begin
        a = 8'($urandom);
        b = 8'($urandom);
      end else begin
        a = 8'h5A;
        b = 8'h3C;
      end
    end
    check("held_pulses", npulses, 3);
    start = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    check("held_final_diff", int'(diff), 8'h1E);

    // Reset in the 4th SHIFT cycle aborts the operation
    @(negedge clk);
    a = 8'hFF;
    b = 8'h01;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_busy_before", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("abort_diff", int'(diff), 0);
    check("abort_borrow", int'(borrow_out), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (done || busy) nd++;
    end
    check("abort_no_done", nd, 0);
    run_op(8'hFF, 8'h01, 8'hFE, 1'b0);

    // Random operand pairs against the arithmetic reference
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op(ra, rb, 8'(ra - rb), ra < rb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
